coin_credit_counter: RTL

Parametrised coin-acceptor credit engine for the vending machine. It debounces N active-low coin switches, accumulates credit with per-channel coin values and saturation rejection, and runs a buy/cancel FSM that issues vend and change. It drives registered two-digit BCD and optional seven-segment outputs to the LCD/display path.

---
 rtl/coin_credit_counter_if.sv | 38 +++
 rtl/coin_credit_counter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : coin_credit_counter_if
// Brief    : Coin switches, purchase controls and credit/display outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface coin_credit_counter_if #(
  parameter int N_COINS  = 3,
  parameter int CREDIT_W = 7
);
  logic [N_COINS-1:0]  chave;
  logic [CREDIT_W-1:0] price;
  logic                buy;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                vend;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_out;
  logic                reject;
  logic                deny;
  logic [3:0]          bcd_tens;
  logic [3:0]          bcd_ones;
  logic [6:0]          seg_tens;
  logic [6:0]          seg_ones;

  modport master (
    output chave, price, buy, cancel,
    input  credit, vend, change_valid, change_out, reject, deny,
    input  bcd_tens, bcd_ones, seg_tens, seg_ones
  );

  modport slave (
    input  chave, price, buy, cancel,
    output credit, vend, change_valid, change_out, reject, deny,
    output bcd_tens, bcd_ones, seg_tens, seg_ones
  );
endinterface
`default_nettype wire

// File: rtl/coin_credit_counter.sv
`default_nettype none
// ============================================================================
// Module   : coin_credit_counter
// Brief    : Debounced coin credit engine with buy/cancel FSM and BCD display.
//            Optional seven-segment decoder enabled by SEG_DECODE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module coin_credit_counter #(
  parameter int                   N_COINS         = 3,
  parameter logic [N_COINS*8-1:0] COIN_VALUES     = {8'd5, 8'd2, 8'd1},
  parameter int                   DEBOUNCE_CYCLES = 15000000,
  parameter int                   CREDIT_W        = 7,
  parameter int                   MAX_CREDIT      = 99
) (
  input wire logic             clock,
  input wire logic             reset_n,
  coin_credit_counter_if.slave bus
);

  localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [c_CNT_W-1:0] c_CNT_HIT = c_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_SAT = c_CNT_W'(DEBOUNCE_CYCLES + 1);
  localparam int                 c_SUM_W   = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
  localparam logic [6:0]         c_SEG_OFF = 7'h7F;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VEND   = 2'd1,
    S_CHANGE = 2'd2
  } state_t;

  logic [N_COINS-1:0]  r_sync1;
  logic [N_COINS-1:0]  r_sync2;
  logic [N_COINS-1:0]  r_pending;
  logic [N_COINS-1:0]  w_press;
  logic [N_COINS-1:0]  w_consume;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [CREDIT_W-1:0] r_price;
  logic [CREDIT_W-1:0] w_price_nxt;
  logic [CREDIT_W-1:0] w_remain;
  logic [c_SUM_W-1:0]  w_sum;
  logic [7:0]          w_value;
  logic                w_found;
  logic                r_reject;
  logic                w_reject_nxt;
  logic                r_deny;
  logic                w_deny_nxt;
  logic                w_vend;
  logic                w_change_valid;
  logic [CREDIT_W-1:0] w_change_out;
  logic [3:0]          r_bcd_tens;
  logic [3:0]          r_bcd_ones;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= bus.chave;
      r_sync2 <= r_sync1;
    end
  end

  // Counter parks one past the threshold so each press fires exactly once.
  for (genvar gi = 0; gi < N_COINS; gi++) begin : g_chan
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        r_cnt <= '0;
      end else if (r_sync2[gi]) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_SAT) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end

    assign w_press[gi] = !r_sync2[gi] && (r_cnt == c_CNT_HIT);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_consume) | w_press;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_price_nxt    = r_price;
    w_reject_nxt   = 1'b0;
    w_deny_nxt     = 1'b0;
    w_consume      = '0;
    w_value        = '0;
    w_found        = 1'b0;
    w_sum          = '0;
    w_vend         = 1'b0;
    w_change_valid = 1'b0;
    w_change_out   = '0;
    w_remain       = r_credit - r_price;

    case (r_state)
      S_IDLE: begin
        if (bus.cancel) begin
          w_state_nxt = S_CHANGE;
        end else if (bus.buy) begin
          if ((bus.price != '0) && (r_credit >= bus.price)) begin
            w_state_nxt = S_VEND;
            w_price_nxt = bus.price;
          end else begin
            w_deny_nxt = 1'b1;
          end
        end else begin
          for (int i = 0; i < N_COINS; i++) begin
            if (r_pending[i] && !w_found) begin
              w_found      = 1'b1;
              w_consume[i] = 1'b1;
              w_value      = COIN_VALUES[8*i +: 8];
            end
          end
          if (w_found) begin
            w_sum = c_SUM_W'(r_credit) + c_SUM_W'(w_value);
            if (w_sum <= c_SUM_W'(MAX_CREDIT)) begin
              w_credit_nxt = CREDIT_W'(w_sum);
            end else begin
              w_reject_nxt = 1'b1;
            end
          end
        end
      end
      S_VEND: begin
        w_vend       = 1'b1;
        w_credit_nxt = w_remain;
        w_state_nxt  = (w_remain != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        w_change_valid = 1'b1;
        w_change_out   = r_credit;
        w_credit_nxt   = '0;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_credit   <= '0;
      r_price    <= '0;
      r_reject   <= 1'b0;
      r_deny     <= 1'b0;
      r_bcd_tens <= '0;
      r_bcd_ones <= '0;
    end else begin
      r_credit   <= w_credit_nxt;
      r_price    <= w_price_nxt;
      r_reject   <= w_reject_nxt;
      r_deny     <= w_deny_nxt;
      r_bcd_tens <= 4'(r_credit / CREDIT_W'(10));
      r_bcd_ones <= 4'(r_credit % CREDIT_W'(10));
    end
  end

  assign bus.credit       = r_credit;
  assign bus.vend         = w_vend;
  assign bus.change_valid = w_change_valid;
  assign bus.change_out   = w_change_out;
  assign bus.reject       = r_reject;
  assign bus.deny         = r_deny;
  assign bus.bcd_tens     = r_bcd_tens;
  assign bus.bcd_ones     = r_bcd_ones;

`ifdef SEG_DECODE_EN
  // Table is active-high abcdefg; the display pins are active-low.
  function automatic logic [6:0] f_seg(input logic [3:0] i_digit);
    logic [6:0] w_pat;
    case (i_digit)
      4'h0: w_pat = 7'h7E;
      4'h1: w_pat = 7'h30;
      4'h2: w_pat = 7'h6D;
      4'h3: w_pat = 7'h79;
      4'h4: w_pat = 7'h33;
      4'h5: w_pat = 7'h5B;
      4'h6: w_pat = 7'h5F;
      4'h7: w_pat = 7'h70;
      4'h8: w_pat = 7'h7F;
      4'h9: w_pat = 7'h7B;
      4'hA: w_pat = 7'h77;
      4'hB: w_pat = 7'h1F;
      4'hC: w_pat = 7'h4E;
      4'hD: w_pat = 7'h3D;
      4'hE: w_pat = 7'h4F;
      default: w_pat = 7'h47;
    endcase
    return ~w_pat;
  endfunction

  assign bus.seg_tens = f_seg(r_bcd_tens);
  assign bus.seg_ones = f_seg(r_bcd_ones);
`else
  assign bus.seg_tens = c_SEG_OFF;
  assign bus.seg_ones = c_SEG_OFF;
`endif

endmodule
`default_nettype wire
